// File: rtl/puc_pkg.sv
// Shared definitions for the PUC stack CPU: opcode numbering, run state and fault codes.
package puc_pkg;

  localparam logic [7:0] LOAD0       = 8'd0;
  localparam logic [7:0] ADD2        = 8'd2;
  localparam logic [7:0] JUMP3       = 8'd3;
  localparam logic [7:0] RESET4      = 8'd4;
  localparam logic [7:0] IF0JUMP5    = 8'd5;
  localparam logic [7:0] IF1JUMP6    = 8'd6;
  localparam logic [7:0] LOADSWITCH7 = 8'd7;
  localparam logic [7:0] CALL8       = 8'd8;
  localparam logic [7:0] EXIT9       = 8'd9;
  localparam logic [7:0] MOVE10      = 8'd10;
  localparam logic [7:0] INCREMENT11 = 8'd11;
  localparam logic [7:0] SUB12       = 8'd12;
  localparam logic [7:0] LSHIFT13    = 8'd13;
  localparam logic [7:0] DECREMENT14 = 8'd14;
  localparam logic [7:0] RSHIFT15    = 8'd15;
  localparam logic [7:0] HALT16      = 8'd16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } cpu_state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERFLOW  = 2'd1,
    FC_UNDERFLOW = 2'd2,
    FC_ILLEGAL   = 2'd3
  } fault_code_t;

endpackage

// File: rtl/param_alu.sv
// Combinational register-to-register ALU; isAlu flags the opcodes it implements.
module param_alu
  import puc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [7:0]            opCode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  isAlu
);

  always_comb begin
    result = '0;
    isAlu  = 1'b1;
    case (opCode)
      ADD2:        result = a + b;
      SUB12:       result = a - b;
      MOVE10:      result = a;
      INCREMENT11: result = a + DATA_WIDTH'(1);
      DECREMENT14: result = a - DATA_WIDTH'(1);
      LSHIFT13:    result = a << 1;
      RSHIFT15:    result = a >> 1;
      default:     isAlu  = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_cpu_core.sv
// Single-cycle PUC CPU core: register file, bounded return stack and RUN/HALTED/FAULT control.
module stack_cpu_core
  import puc_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_REGS     = 16,
  parameter  int PC_WIDTH     = 8,
  parameter  int VALUE_WIDTH  = 8,
  parameter  int STACK_DEPTH  = 16,
  parameter  int SWITCH_WIDTH = 1,
  localparam int REG_IDX_W    = $clog2(NUM_REGS),
  localparam int INSTR_WIDTH  = 8 + 3*REG_IDX_W + VALUE_WIDTH,
  localparam int SD_W         = $clog2(STACK_DEPTH+1)
) (
  input  logic                    clock,
  input  logic                    isReset,
  input  logic                    enable,
  input  logic [INSTR_WIDTH-1:0]  instruction,
  input  logic [SWITCH_WIDTH-1:0] switch,
  input  logic [REG_IDX_W-1:0]    dbgSel,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [7:0]              opCode,
  output logic [DATA_WIDTH-1:0]   dbgValue,
  output logic [SD_W-1:0]         stackDepth,
  output logic [1:0]              cpuState,
  output logic [1:0]              faultCode
);

  localparam int              SP_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SD_W-1:0] FULL_DEPTH = SD_W'(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];

  logic [PC_WIDTH-1:0]   pc_reg, pc_next, pc_plus1, target;
  logic [SD_W-1:0]       depth_reg, depth_next, depth_m1;
  logic [SP_W-1:0]       push_idx, pop_idx;
  cpu_state_t            state_reg, state_next;
  fault_code_t           fault_reg, fault_next;

  logic [REG_IDX_W-1:0]   ra, rb, rd;
  logic [VALUE_WIDTH-1:0] value;
  logic [DATA_WIDTH-1:0]  a, b, alu_result, reg_wdata;
  logic                   alu_valid, reg_we, push, soft_reset;

  assign opCode = instruction[INSTR_WIDTH-1 -: 8];
  assign ra     = instruction[VALUE_WIDTH + 3*REG_IDX_W - 1 -: REG_IDX_W];
  assign rb     = instruction[VALUE_WIDTH + 2*REG_IDX_W - 1 -: REG_IDX_W];
  assign rd     = instruction[VALUE_WIDTH + REG_IDX_W - 1 -: REG_IDX_W];
  assign value  = instruction[VALUE_WIDTH-1:0];
  assign target = value[PC_WIDTH-1:0];

  // r0 is zeroed by reset and never written, so a plain array read returns 0 for it.
  assign a        = regs_reg[ra];
  assign b        = regs_reg[rb];
  assign dbgValue = regs_reg[dbgSel];

  assign pc_plus1 = pc_reg + PC_WIDTH'(1);
  assign depth_m1 = depth_reg - SD_W'(1);
  assign push_idx = depth_reg[SP_W-1:0];
  assign pop_idx  = depth_m1[SP_W-1:0];

  assign pc         = pc_reg;
  assign stackDepth = depth_reg;
  assign cpuState   = state_reg;
  assign faultCode  = fault_reg;

  param_alu #(.DATA_WIDTH(DATA_WIDTH)) alu_inst (
    .opCode (opCode),
    .a      (a),
    .b      (b),
    .result (alu_result),
    .isAlu  (alu_valid)
  );

  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    state_next = state_reg;
    fault_next = fault_reg;
    reg_we     = 1'b0;
    reg_wdata  = alu_result;
    push       = 1'b0;
    soft_reset = 1'b0;
    if (enable && state_reg == RUN) begin
      case (opCode)
        LOAD0: begin
          reg_we    = 1'b1;
          reg_wdata = DATA_WIDTH'(value);
          pc_next   = pc_plus1;
        end
        LOADSWITCH7: begin
          reg_we    = 1'b1;
          reg_wdata = DATA_WIDTH'(switch);
          pc_next   = pc_plus1;
        end
        JUMP3:    pc_next = target;
        RESET4:   soft_reset = 1'b1;
        IF0JUMP5: pc_next = (a == '0) ? target : pc_plus1;
        IF1JUMP6: pc_next = (a != '0) ? target : pc_plus1;
        CALL8: begin
          if (depth_reg == FULL_DEPTH) begin
            state_next = FAULT;
            fault_next = FC_OVERFLOW;
          end else begin
            push       = 1'b1;
            depth_next = depth_reg + SD_W'(1);
            pc_next    = target;
          end
        end
        EXIT9: begin
          if (depth_reg == '0) begin
            state_next = FAULT;
            fault_next = FC_UNDERFLOW;
          end else begin
            depth_next = depth_m1;
            pc_next    = stack_mem[pop_idx];
          end
        end
        HALT16: state_next = HALTED;
        default: begin
          if (alu_valid) begin
            reg_we  = 1'b1;
            pc_next = pc_plus1;
          end else begin
            state_next = FAULT;
            fault_next = FC_ILLEGAL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (isReset || soft_reset) begin
      pc_reg    <= '0;
      depth_reg <= '0;
      state_reg <= RUN;
      fault_reg <= FC_NONE;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      state_reg <= state_next;
      fault_reg <= fault_next;
      if (reg_we && rd != '0) regs_reg[rd] <= reg_wdata;
    end
  end

  // Stack contents need no reset; only the depth counter defines what is valid.
  always_ff @(posedge clock) begin
    if (push && !isReset) stack_mem[push_idx] <= pc_plus1;
  end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed bench for stack_cpu_core: programs run from a bench-side memory, checked against hand values.
module tb_stack_cpu_core;
  import puc_pkg::*;

  localparam int INSTR_W = 28;

  logic               clock = 1'b0;
  logic               isReset;
  logic               enable;
  logic [INSTR_W-1:0] instruction;
  logic [0:0]         switch;
  logic [3:0]         dbgSel;
  logic [7:0]         pc;
  logic [7:0]         opCode;
  logic [7:0]         dbgValue;
  logic [4:0]         stackDepth;
  logic [1:0]         cpuState;
  logic [1:0]         faultCode;

  logic [INSTR_W-1:0] imem [256];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;
  assign instruction = imem[pc];

  stack_cpu_core dut (
    .clock       (clock),
    .isReset     (isReset),
    .enable      (enable),
    .instruction (instruction),
    .switch      (switch),
    .dbgSel      (dbgSel),
    .pc          (pc),
    .opCode      (opCode),
    .dbgValue    (dbgValue),
    .stackDepth  (stackDepth),
    .cpuState    (cpuState),
    .faultCode   (faultCode)
  );

  function automatic logic [INSTR_W-1:0] enc(input logic [7:0] op, input logic [3:0] ra,
                                             input logic [3:0] rb, input logic [3:0] rd,
                                             input logic [7:0] val);
    return {op, ra, rb, rd, val};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    dbgSel = idx;
    #1;
    check(tag, dbgValue, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic apply_reset();
    isReset = 1'b1;
    step();
    isReset = 1'b0;
  endtask

  task automatic chain_program();
    clear_mem();
    for (int k = 0; k < 16; k++) begin
      imem[2*k]   = enc(CALL8, 0, 0, 0, 8'(2*k + 2));
      imem[2*k+1] = enc(EXIT9, 0, 0, 0, 8'h00);
    end
    imem[32] = enc(EXIT9, 0, 0, 0, 8'h00);
  endtask

  initial begin
    enable  = 1'b1;
    isReset = 1'b0;
    switch  = 1'b1;
    dbgSel  = '0;

    // Arithmetic, register 0 and switch load
    clear_mem();
    imem[0]  = enc(LOAD0,       0,  0,  3, 8'h05);
    imem[1]  = enc(LOAD0,       0,  0,  4, 8'h03);
    imem[2]  = enc(SUB12,       3,  4,  5, 8'h00);
    imem[3]  = enc(ADD2,        3,  4,  6, 8'h00);
    imem[4]  = enc(LOAD0,       0,  0,  0, 8'h55);
    imem[5]  = enc(LOAD0,       0,  0,  7, 8'hFF);
    imem[6]  = enc(LOAD0,       0,  0,  8, 8'h01);
    imem[7]  = enc(ADD2,        7,  8,  9, 8'h00);
    imem[8]  = enc(DECREMENT14, 0,  0, 10, 8'h00);
    imem[9]  = enc(LOAD0,       0,  0, 11, 8'h81);
    imem[10] = enc(LSHIFT13,   11,  0, 12, 8'h00);
    imem[11] = enc(RSHIFT15,   11,  0, 13, 8'h00);
    imem[12] = enc(INCREMENT11, 6,  0, 14, 8'h00);
    imem[13] = enc(MOVE10,      5,  0, 15, 8'h00);
    imem[14] = enc(LOADSWITCH7, 0,  0,  1, 8'h00);
    imem[15] = enc(ADD2,        3,  3,  3, 8'h00);
    imem[16] = enc(HALT16,      0,  0,  0, 8'h00);
    apply_reset();
    check("reset_pc", pc, 8'h00);
    check("reset_state", cpuState, 2'd0);
    check("reset_fault", faultCode, 2'd0);
    check("reset_depth", stackDepth, 5'd0);
    check("reset_opcode", opCode, 8'h00);
    repeat (4) step();
    check_reg("r5_sub_early", 4'd5, 8'h02);
    repeat (13) step();
    check("halt_state", cpuState, 2'd1);
    check("halt_pc", pc, 8'd16);
    check("halt_opcode", opCode, 8'd16);
    check_reg("r3_self_add", 4'd3,  8'h0A);
    check_reg("r4_load",     4'd4,  8'h03);
    check_reg("r5_sub",      4'd5,  8'h02);
    check_reg("r6_add",      4'd6,  8'h08);
    check_reg("r0_zero",     4'd0,  8'h00);
    check_reg("r7_load_ff",  4'd7,  8'hFF);
    check_reg("r9_add_wrap", 4'd9,  8'h00);
    check_reg("r10_dec_wrap",4'd10, 8'hFF);
    check_reg("r12_lshift",  4'd12, 8'h02);
    check_reg("r13_rshift",  4'd13, 8'h40);
    check_reg("r14_inc",     4'd14, 8'h09);
    check_reg("r15_move",    4'd15, 8'h02);
    check_reg("r1_switch",   4'd1,  8'h01);
    repeat (10) step();
    check("halt_pc_held", pc, 8'd16);
    check("halt_state_held", cpuState, 2'd1);

    // Conditional jumps and enable gating
    clear_mem();
    imem[8'h00] = enc(IF0JUMP5, 2, 0, 0, 8'h10);
    imem[8'h10] = enc(IF1JUMP6, 2, 0, 0, 8'h30);
    imem[8'h11] = enc(LOAD0,    0, 0, 2, 8'h07);
    imem[8'h12] = enc(IF1JUMP6, 2, 0, 0, 8'h20);
    imem[8'h20] = enc(JUMP3,    0, 0, 0, 8'h40);
    imem[8'h40] = enc(HALT16,   0, 0, 0, 8'h00);
    apply_reset();
    step();
    check("if0_taken_pc", pc, 8'h10);
    step();
    check("if1_not_taken_pc", pc, 8'h11);
    enable = 1'b0;
    repeat (3) step();
    check("disabled_pc", pc, 8'h11);
    check_reg("disabled_r2", 4'd2, 8'h00);
    enable = 1'b1;
    step();
    check("enabled_pc", pc, 8'h12);
    check_reg("enabled_r2", 4'd2, 8'h07);
    step();
    check("if1_taken_pc", pc, 8'h20);
    step();
    check("jump_pc", pc, 8'h40);

    // Nested calls to full depth, unwind, then underflow
    chain_program();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("call%0d_pc", i), pc, 32'(2*i + 2));
      check($sformatf("call%0d_depth", i), stackDepth, 32'(i + 1));
    end
    for (int j = 0; j < 16; j++) begin
      step();
      check($sformatf("exit%0d_pc", j), pc, 32'(31 - 2*j));
      check($sformatf("exit%0d_depth", j), stackDepth, 32'(15 - j));
    end
    step();
    check("underflow_state", cpuState, 2'd2);
    check("underflow_code", faultCode, 2'd2);
    check("underflow_pc", pc, 8'd1);
    repeat (2) step();
    check("underflow_sticky_pc", pc, 8'd1);
    check("underflow_sticky_state", cpuState, 2'd2);
    apply_reset();
    check("clear_pc", pc, 8'd0);
    check("clear_state", cpuState, 2'd0);
    check("clear_code", faultCode, 2'd0);

    // Overflow at full depth; reset while enable is low
    chain_program();
    imem[32] = enc(CALL8, 0, 0, 0, 8'h80);
    apply_reset();
    repeat (16) step();
    check("full_depth", stackDepth, 5'd16);
    step();
    check("overflow_state", cpuState, 2'd2);
    check("overflow_code", faultCode, 2'd1);
    check("overflow_pc", pc, 8'd32);
    check("overflow_depth", stackDepth, 5'd16);
    enable = 1'b0;
    apply_reset();
    enable = 1'b1;
    check("reset_disabled_pc", pc, 8'd0);
    check("reset_disabled_state", cpuState, 2'd0);
    check("reset_disabled_code", faultCode, 2'd0);
    check("reset_disabled_depth", stackDepth, 5'd0);

    // Illegal opcode leaves its destination untouched
    clear_mem();
    imem[0] = enc(LOAD0, 0, 0, 1, 8'h05);
    imem[1] = enc(8'h2A, 1, 1, 1, 8'h09);
    apply_reset();
    repeat (2) step();
    check("illegal_state", cpuState, 2'd2);
    check("illegal_code", faultCode, 2'd3);
    check("illegal_pc", pc, 8'd1);
    check_reg("illegal_r1", 4'd1, 8'h05);

    // RESET4 behaves like isReset
    clear_mem();
    imem[8'h00] = enc(LOAD0,  0, 0, 1, 8'h05);
    imem[8'h01] = enc(CALL8,  0, 0, 0, 8'h10);
    imem[8'h10] = enc(RESET4, 0, 0, 0, 8'h00);
    apply_reset();
    repeat (2) step();
    check("pre_soft_depth", stackDepth, 5'd1);
    step();
    check("soft_reset_pc", pc, 8'd0);
    check("soft_reset_depth", stackDepth, 5'd0);
    check_reg("soft_reset_r1", 4'd1, 8'h00);

    // Return address pushed from pc 0xFF wraps to 0
    clear_mem();
    imem[8'h00] = enc(JUMP3, 0, 0, 0, 8'hFF);
    imem[8'hFF] = enc(CALL8, 0, 0, 0, 8'h50);
    imem[8'h50] = enc(EXIT9, 0, 0, 0, 8'h00);
    apply_reset();
    repeat (2) step();
    check("wrap_call_pc", pc, 8'h50);
    step();
    check("wrap_return_pc", pc, 8'h00);
    check("wrap_return_depth", stackDepth, 5'd0);

    // isReset in the same cycle as a CALL
    clear_mem();
    imem[8'h00] = enc(CALL8, 0, 0, 0, 8'h20);
    imem[8'h20] = enc(CALL8, 0, 0, 0, 8'h30);
    apply_reset();
    step();
    check("midcall_depth_before", stackDepth, 5'd1);
    isReset = 1'b1;
    step();
    isReset = 1'b0;
    check("midcall_pc", pc, 8'd0);
    check("midcall_depth", stackDepth, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_cpu_core.md
# stack_cpu_core

Parametrised single-cycle successor to the current PUC CPU core. Executes one instruction per enabled clock from a combinational instruction memory, with a general register file, a bounded return stack, and a RUN/HALTED/FAULT state machine. Sits between the instruction `MEMORY` block and the board I/O (switch in, debug register view and status out).

## Interface
Parameters:
- `DATA_WIDTH`, 8: register and ALU width.
- `NUM_REGS`, 16: register count, power of two ≥ 4; `REG_IDX_W = $clog2(NUM_REGS)`.
- `PC_WIDTH`, 8: program counter width.
- `VALUE_WIDTH`, 8: immediate field width, ≥ `PC_WIDTH`.
- `STACK_DEPTH`, 16: return-stack entries, ≥ 1.
- `SWITCH_WIDTH`, 1: switch input width, ≤ `DATA_WIDTH`.
- Derived: `INSTR_WIDTH = 8 + 3*REG_IDX_W + VALUE_WIDTH`.

Ports:
- `clock`, in, 1: the only clock.
- `isReset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: when low, no architectural state changes.
- `instruction`, in, `INSTR_WIDTH`: word at `pc`, combinational from `MEMORY`.
- `switch`, in, `SWITCH_WIDTH`: board switches.
- `dbgSel`, in, `REG_IDX_W`: register to view.
- `pc`, out, `PC_WIDTH`: program counter.
- `opCode`, out, 8: decoded opcode field.
- `dbgValue`, out, `DATA_WIDTH`: combinational `registers[dbgSel]`.
- `stackDepth`, out, `$clog2(STACK_DEPTH+1)`: occupied stack entries.
- `cpuState`, out, 2: 0 RUN, 1 HALTED, 2 FAULT.
- `faultCode`, out, 2: 0 none, 1 overflow, 2 underflow, 3 illegal opcode.

## Operation
- Fields, MSB first: opcode[8], rA, rB, rD (each `REG_IDX_W`), value[`VALUE_WIDTH`].
- Register 0 always reads 0. Writes to it are dropped.
- Opcodes keep existing numbering:
  - LOAD0: rD ← zero-extended or truncated value.
  - ADD2: rD ← rA + rB.
  - JUMP3: pc ← value.
  - RESET4: same effect as `isReset`.
  - IF0JUMP5: jump if rA == 0, else pc+1.
  - IF1JUMP6: jump if rA != 0, else pc+1.
  - LOADSWITCH7: rD ← zero-extended switch.
  - CALL8: push pc+1, pc ← value.
  - EXIT9: pop into pc.
  - MOVE10: rD ← rA.
  - INCREMENT11: rD ← rA+1.
  - SUB12: rD ← rA − rB.
  - LSHIFT13: rD ← rA<<1, zero fill.
  - DECREMENT14: rD ← rA−1.
  - RSHIFT15: rD ← rA>>1, zero fill.
  - HALT16: enter HALTED.
  - Every other opcode is illegal.
- Arithmetic is modulo 2^`DATA_WIDTH`; no carry or flags. Jump and call targets use value[`PC_WIDTH`-1:0]. pc+1 wraps.
- State machine:
  - RUN→HALTED on HALT16; pc is not advanced.
  - RUN→FAULT on CALL8 with `stackDepth == STACK_DEPTH` (code 1), on EXIT9 with `stackDepth == 0` (code 2), or on an illegal opcode (code 3).
  - A faulting instruction makes no push, pop, register or pc change.
  - HALTED and FAULT are sticky. They leave only on `isReset` or RESET4; RESET4 is not fetched while halted, so in practice only `isReset`.
- Outside RUN, or with `enable` low: pc, registers, stack, `stackDepth` and `cpuState` all hold.

## Timing
- All updates occur on posedge `clock`. Operands are read from pre-edge register values, so an instruction whose rD equals its rA sees the old value.
- Latency: one instruction per enabled cycle. A write is visible on `dbgValue` the cycle after the edge.
- Reset values (`isReset` sampled high): pc 0, all registers 0, `stackDepth` 0, `cpuState` RUN, `faultCode` 0. Stack contents are don't-care.
- `isReset` wins over `enable`, over any opcode, and over a pending fault.
- CALL and EXIT at boundaries:
  - CALL at depth `STACK_DEPTH`−1 succeeds and depth becomes `STACK_DEPTH`.
  - EXIT at depth 1 succeeds and depth becomes 0.
  - The entry pushed at pc = 2^`PC_WIDTH`−1 is 0.
- `opCode`, `dbgValue`, `cpuState` and `faultCode` are valid throughout the cycle. `opCode` follows `instruction` combinationally.

## Structure
- Package `puc_pkg` holds:
  - the opcode localparams (existing names plus MOVE10, SUB12, HALT16);
  - the `cpu_state_t` enum (RUN, HALTED, FAULT);
  - the `fault_code_t` enum.
- Sub-module `param_alu`: combinational, parametrised by `DATA_WIDTH`. Inputs are opCode, a and b; outputs are result and isAlu.
- Return stack and register file stay inline as arrays.

## Test plan
- Reset then LOAD r3←0x05, LOAD r4←0x03, SUB r5←r3−r4, ADD r6←r3+r4 → `dbgValue`(r5)=0x02, (r6)=0x08. LOAD r0←0x55 → r0 reads 0.
- ADD 0xFF+0x01 gives 0x00. DECREMENT of 0x00 gives 0xFF. LSHIFT of 0x81 gives 0x02. RSHIFT of 0x81 gives 0x40.
- Nested CALLs to depth `STACK_DEPTH` then EXITs → each return lands on its caller+1. One more CALL at full depth → `cpuState`=2, `faultCode`=1, and pc is frozen at the CALL address.
- EXIT at depth 0 → FAULT with code 2. Opcode 0x2A → FAULT with code 3. `isReset` then clears to pc 0, RUN, code 0.
- IF0JUMP5 on r2=0 jumps to 0x10. IF1JUMP6 on r2=0 goes to pc+1. With `enable` low for 3 cycles, pc and registers are unchanged.
- HALT16 → `cpuState`=1, pc held for 10 cycles. `isReset` asserted mid-CALL, in the same cycle → pc 0, `stackDepth` 0.
